// File: rtl/neuron_spike_rate_counter_if.sv
// Result port of the spike rate counter: one count/saturation pair
// qualified by valid, accepted by the consumer with ready.
interface neuron_spike_rate_counter_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] out_count;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_count, output out_sat, output out_valid, input out_ready);
    modport slave  (input out_count, input out_sat, input out_valid, output out_ready);
endinterface

// File: rtl/neuron_spike_rate_counter.sv
// Counts neuron fire samples over back-to-back windows of enabled cycles and
// hands each window's count to readout through a one-entry result register.
module neuron_spike_rate_counter #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        spike_in,
    input  logic                        run,
    input  logic [WIN_W-1:0]            cfg_win,
    neuron_spike_rate_counter_if.master out_if,
    output logic                        lost,
    output logic                        busy,
    output logic                        dbg_state
);
    typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    state_t           state, state_nx;
    logic [WIN_W-1:0] win_len, win_cnt;
    logic [CNT_W-1:0] acc, acc_nx;
    logic             sat_flag, sat_nx;
    logic             start, step, win_end, take;

    // Handshake: a result transfers on an edge where out_valid && out_ready;
    // out_count/out_sat hold while out_valid is high and unread, and
    // out_ready has no effect while out_valid is low.
    assign take      = out_if.out_valid && out_if.out_ready;
    assign busy      = (state == COUNT);
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        step     = 1'b0;
        win_end  = 1'b0;
        acc_nx   = acc;
        sat_nx   = sat_flag;
        case (state)
            IDLE: begin
                if (run) begin
                    start    = 1'b1;
                    state_nx = COUNT;
                end
            end
            COUNT: begin
                if (ena) begin
                    step = 1'b1;
                    if (spike_in) begin
                        if (acc == CNT_MAX) sat_nx = 1'b1;
                        else                acc_nx = acc + 1'b1;
                    end
                    // The closing sample is folded into acc_nx, so the result
                    // leaves on the same edge that samples it.
                    if (win_cnt == win_len - WIN_ONE) begin
                        win_end = 1'b1;
                        if (run) start    = 1'b1;
                        else     state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            win_len  <= WIN_ONE;
            win_cnt  <= '0;
            acc      <= '0;
            sat_flag <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                win_len  <= (cfg_win == '0) ? WIN_ONE : cfg_win;
                win_cnt  <= '0;
                acc      <= '0;
                sat_flag <= 1'b0;
            end else if (step) begin
                win_cnt  <= win_cnt + WIN_ONE;
                acc      <= acc_nx;
                sat_flag <= sat_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_if.out_count <= '0;
            out_if.out_sat   <= 1'b0;
            out_if.out_valid <= 1'b0;
            lost             <= 1'b0;
        end else begin
            if (start && state == IDLE) lost <= 1'b0;
            if (win_end) begin
                if (!out_if.out_valid || take) begin
                    out_if.out_count <= acc_nx;
                    out_if.out_sat   <= sat_nx;
                    out_if.out_valid <= 1'b1;
                end else begin
                    lost <= 1'b1;
                end
            end else if (take) begin
                out_if.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/neuron_spike_rate_counter.md
Name: neuron_spike_rate_counter

Overview:
- Downstream stage of tt_um_neuron. Consumes the neuron's single-bit fire output (uo_out[0]).
- Counts fire pulses over back-to-back windows of a programmable number of enabled cycles.
- Presents each window's spike count through a one-entry valid/ready output register to the readout logic.
- Gives a rate-coded view of neuron activity.

Parameters:
- CNT_W, 8, width of the spike count and out_count; count saturates at 2^CNT_W-1.
- WIN_W, 8, width of cfg_win (window length in enabled cycles).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- ena  input  1  design enable; when low, no window cycle elapses and spike_in is ignored.
- spike_in  input  1  neuron fire output; level sampled once per enabled cycle, with no edge detection.
- run  input  1  level; high starts and continues windowing.
- cfg_win  input  WIN_W  window length in enabled cycles; latched at every window start; value 0 is treated as 1.
- out_count  output  CNT_W  spike count of the completed window.
- out_sat  output  1  the window's count saturated.
- out_valid  output  1  out_count/out_sat hold an unread result.
- out_ready  input  1  consumer accepts the result when out_valid && out_ready.
- lost  output  1  sticky flag: a completed window was discarded because the output register was full.
- busy  output  1  high in COUNT state.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is synchronous, active-low, on rst_n, sampled at the clk rising edge.
  - Reset forces state IDLE and clears acc, win_cnt, out_count, out_sat, out_valid, lost and busy to 0.
  - Reset mid-window discards the partial count.
- States: IDLE, COUNT.
  - IDLE: if run=1 at an edge, latch win_len = (cfg_win==0 ? 1 : cfg_win), clear acc and win_cnt, go to COUNT. busy=1 from the next cycle.
  - COUNT, on each edge with ena=1:
    - win_cnt increments.
    - If spike_in=1, acc increments, saturating at 2^CNT_W-1.
    - sat_flag sets if an increment was attempted at max.
  - COUNT, edge with ena=0: nothing changes.
- Window end:
  - Occurs on the enabled edge where win_cnt == win_len-1; that cycle's spike is included.
  - The final value (acc+spike, saturated) is offered to the output register at that same edge.
  - If run=1, a new window starts immediately: win_len re-latched from cfg_win, acc and win_cnt cleared, no gap cycle.
  - If run=0, go to IDLE. A partial window is never aborted by run deassertion.
- Output register:
  - Empty, or being read that edge (out_valid && out_ready): load the result; out_valid=1 on the next cycle. Latency is 1 edge from the last sampled spike to out_valid.
  - Full and not being read: keep the old result, discard the new one, set lost=1.
  - Handshake with no new result: out_valid clears.
  - out_count and out_sat are stable while out_valid=1 && out_ready=0.
  - out_ready is ignored when out_valid=0.
- lost: cleared only by reset or by the IDLE→COUNT transition.
- Arithmetic:
  - acc is CNT_W bits, unsigned.
  - With win_len > 2^CNT_W-1, counts clip at 2^CNT_W-1 and out_sat=1.
- Simultaneous cases:
  - Window end and handshake on the same edge: the new result replaces the old; out_valid stays 1; lost is unchanged.
  - run rising while in COUNT: no effect.

Test Plan:
1. Reset, run=1, cfg_win=4, ena=1, spike_in=1,0,1,1 → out_valid rises one edge after the 4th sample; out_count=3; out_sat=0; busy stays 1 into the next window.
2. cfg_win=0, spike_in=1 constant, out_ready=1 → a result every cycle, out_count=1 each time.
3. CNT_W=8, cfg_win=255, spike_in=1 constant → out_count=255, out_sat=0. Repeat with CNT_W=4, cfg_win=20 → out_count=15, out_sat=1.
4. cfg_win=3, out_ready=0 for two windows → first count retained, lost=1. Raise out_ready for 1 cycle → out_valid=0. Drop run; next run rise → lost=0.
5. cfg_win=4, ena toggling 1,0,1,0,... with spike_in=1 → window completes after 8 clocks; out_count=4.
6. Assert rst_n=0 for 1 cycle mid-window (after 2 of 5 samples) with out_valid=1 → next cycle out_valid=0, busy=0, state IDLE. Deassert run mid-window → window completes, then busy=0.
